// File: rtl/com_multi.sv
// rtl/com_multi.sv - NCH-channel ASCII hex register bridge over one UART pair
// Optional macro COM_QUERY_EN adds 'R'<ch> readback queries.

module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_ready
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
  r_state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          rx_s1, rx_s2;
  logic          bit_end, half_end;

  assign bit_end  = (cnt == CW'(DIV - 1));
  assign half_end = (cnt == CW'(DIV / 2 - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= R_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      R_IDLE:  if (!rx_s2) state_nx = R_START;
      R_START: if (half_end) state_nx = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (bit_end && bitn == 3'd7) state_nx = R_STOP;
      R_STOP:  if (bit_end) state_nx = R_IDLE;
      default: state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_s1    <= RX;
      rx_s2    <= rx_s1;
      rx_ready <= 1'b0;
      case (state)
        R_IDLE: begin
          cnt  <= '0;
          bitn <= '0;
        end
        R_START: cnt <= half_end ? '0 : cnt + 1'b1;
        R_DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            bitn  <= bitn + 3'd1;
            shreg <= {rx_s2, shreg[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // a low stop bit is a framing error: drop the byte
          if (bit_end) begin
            cnt <= '0;
            if (rx_s2) begin
              rx_data  <= shreg;
              rx_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

module uart_tx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       TX
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;

  typedef enum logic {U_IDLE, U_SEND} u_state_t;
  u_state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [9:0]    sh;
  logic          bit_end;

  assign bit_end = (cnt == CW'(DIV - 1));
  assign tx_busy = (state == U_SEND);
  assign TX      = (state == U_SEND) ? sh[0] : 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) state <= U_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == U_IDLE) begin
      if (tx_start) state_nx = U_SEND;
    end else if (bit_end && bitn == 4'd9) begin
      state_nx = U_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      bitn <= '0;
      sh   <= '1;
    end else if (state == U_IDLE) begin
      cnt  <= '0;
      bitn <= '0;
      if (tx_start) sh <= {1'b1, tx_data, 1'b0};
    end else if (bit_end) begin
      cnt  <= '0;
      bitn <= bitn + 4'd1;
      sh   <= {1'b1, sh[9:1]};
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module com_multi #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200,
  parameter int NCH      = 4,
  parameter int DW       = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RX,
  output logic            TX,
  output logic [NCH*DW-1:0] DATA_IN,
  output logic [NCH-1:0]  DATA_IN_STB,
  input  logic [NCH*DW-1:0] DATA_OUT
);
  localparam int NIB = DW / 4;

  typedef enum logic [1:0] {
    P_WAIT, P_CH, P_DAT
`ifdef COM_QUERY_EN
    , P_QCH
`endif
  } p_state_t;
  typedef enum logic {T_IDLE, T_SEND} t_state_t;

  p_state_t p_state, p_nx;
  t_state_t t_state, t_nx;

  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [4:0]    rx_hex;
  logic [3:0]    ch_reg;
  logic [2:0]    nib_cnt;
  logic [DW-1:0] wr_shift, wr_word;
  logic          wr_fire;

  logic          q_pend;
  logic [3:0]    q_ch;

  logic [DW-1:0] shadow [NCH];
  logic [3:0]    ptr, sel, t_ch, t_idx, t_last;
  logic [DW-1:0] sel_val, sel_shadow, t_data;
  logic          sel_ok, t_err, start_frame, byte_acc;
  logic [7:0]    cur_byte, tx_data;
  logic          tx_start, tx_busy;
  int            nib_sh;

  // {valid, value}
  function automatic logic [4:0] hex_dec(input logic [7:0] b);
    if (b >= "0" && b <= "9") return {1'b1, 4'(b - "0")};
    if (b >= "A" && b <= "F") return {1'b1, 4'(b - "A" + 8'd10)};
    if (b >= "a" && b <= "f") return {1'b1, 4'(b - "a" + 8'd10)};
    return 5'd0;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'b0, n} : 8'h37 + {4'b0, n};
  endfunction

  function automatic p_state_t frame_start(input logic [7:0] b);
    if (b == "S") return P_CH;
`ifdef COM_QUERY_EN
    if (b == "R") return P_QCH;
`endif
    return P_WAIT;
  endfunction

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .CLK(CLK), .RST(RST), .RX(RX), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
    .CLK(CLK), .RST(RST), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .TX(TX)
  );

  assign rx_hex  = hex_dec(rx_data);
  assign wr_word = (wr_shift << 4) | DW'(rx_hex[3:0]);

`ifdef COM_QUERY_EN
  logic q_set;
`endif

  always_ff @(posedge CLK) begin
    if (RST) p_state <= P_WAIT;
    else     p_state <= p_nx;
  end

  always_comb begin
    p_nx    = p_state;
    wr_fire = 1'b0;
`ifdef COM_QUERY_EN
    q_set   = 1'b0;
`endif
    if (rx_ready) begin
      case (p_state)
        P_WAIT: p_nx = frame_start(rx_data);
        P_CH:   p_nx = rx_hex[4] ? P_DAT : frame_start(rx_data);
        P_DAT: begin
          if (!rx_hex[4]) begin
            p_nx = frame_start(rx_data);
          end else if (nib_cnt == 3'd0) begin
            p_nx    = P_WAIT;
            wr_fire = 1'b1;
          end
        end
`ifdef COM_QUERY_EN
        P_QCH: begin
          if (rx_hex[4]) begin
            p_nx  = P_WAIT;
            q_set = 1'b1;
          end else begin
            p_nx = frame_start(rx_data);
          end
        end
`endif
        default: p_nx = P_WAIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_reg      <= '0;
      nib_cnt     <= '0;
      wr_shift    <= '0;
      DATA_IN     <= '0;
      DATA_IN_STB <= '0;
    end else begin
      DATA_IN_STB <= '0;
      if (rx_ready && rx_hex[4]) begin
        if (p_state == P_CH) begin
          ch_reg   <= rx_hex[3:0];
          nib_cnt  <= 3'(NIB - 1);
          wr_shift <= '0;
        end else if (p_state == P_DAT) begin
          wr_shift <= wr_word;
          nib_cnt  <= nib_cnt - 3'd1;
        end
      end
      // out-of-range channels match no iteration and are silently dropped
      if (wr_fire) begin
        for (int c = 0; c < NCH; c++) begin
          if (ch_reg == 4'(c)) begin
            DATA_IN[c*DW +: DW] <= wr_word;
            DATA_IN_STB[c]      <= 1'b1;
          end
        end
      end
    end
  end

`ifdef COM_QUERY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_pend <= 1'b0;
      q_ch   <= '0;
    end else if (q_set) begin
      q_pend <= 1'b1;
      q_ch   <= rx_hex[3:0];
    end else if (t_state == T_IDLE) begin
      q_pend <= 1'b0;
    end
  end
`else
  assign q_pend = 1'b0;
  assign q_ch   = 4'd0;
`endif

  // a pending query takes the slot the change scan would otherwise use
  always_comb begin
    sel        = q_pend ? q_ch : ptr;
    sel_ok     = 1'b0;
    sel_val    = '0;
    sel_shadow = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel == 4'(c)) begin
        sel_ok     = 1'b1;
        sel_val    = DATA_OUT[c*DW +: DW];
        sel_shadow = shadow[c];
      end
    end
  end

  assign start_frame = (t_state == T_IDLE) && (q_pend || sel_val != sel_shadow);
  assign byte_acc    = tx_busy && tx_start;
  assign t_last      = t_err ? 4'd2 : 4'(NIB + 2);

  always_ff @(posedge CLK) begin
    if (RST) t_state <= T_IDLE;
    else     t_state <= t_nx;
  end

  always_comb begin
    t_nx = t_state;
    if (t_state == T_IDLE) begin
      if (start_frame) t_nx = T_SEND;
    end else if (byte_acc && t_idx == t_last) begin
      t_nx = T_IDLE;
    end
  end

  always_comb begin
    nib_sh   = 4 * (NIB + 1 - int'(t_idx));
    cur_byte = hex_char(4'(t_data >> nib_sh));
    if (t_idx == 4'd0)       cur_byte = t_err ? "E" : "D";
    else if (t_idx == 4'd1)  cur_byte = hex_char(t_ch);
    else if (t_idx == t_last) cur_byte = 8'h0A;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr      <= '0;
      t_idx    <= '0;
      t_err    <= 1'b0;
      t_ch     <= '0;
      t_data   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      for (int c = 0; c < NCH; c++) shadow[c] <= '0;
    end else if (t_state == T_IDLE) begin
      if (!q_pend) ptr <= (ptr == 4'(NCH - 1)) ? 4'd0 : ptr + 4'd1;
      if (start_frame) begin
        t_idx  <= '0;
        t_ch   <= sel;
        t_err  <= !sel_ok;
        t_data <= sel_val;
        for (int c = 0; c < NCH; c++) begin
          if (sel == 4'(c)) shadow[c] <= sel_val;
        end
      end
    end else if (!tx_busy && !tx_start) begin
      tx_data  <= cur_byte;
      tx_start <= 1'b1;
    end else if (byte_acc) begin
      tx_start <= 1'b0;
      t_idx    <= t_idx + 4'd1;
    end
  end
endmodule

// File: tb/tb_com_multi.sv
// tb/tb_com_multi.sv - scoreboard bench for com_multi (UART byte model on RX and TX)
// Define COM_QUERY_EN for both files to exercise readback with DW=16.

module tb_com_multi;
`ifdef COM_QUERY_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam int NCH = 4;
  localparam int NIB = DW / 4;
  localparam int FL  = NIB + 3;
  localparam int BIT = 16;

  logic              CLK, RST, RX, TX;
  logic [NCH*DW-1:0] DATA_IN, DATA_OUT;
  logic [NCH-1:0]    DATA_IN_STB;

  com_multi #(.CLK_FREQ(1_843_200), .BAUD(115200), .NCH(NCH), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .TX(TX),
    .DATA_IN(DATA_IN), .DATA_IN_STB(DATA_IN_STB), .DATA_OUT(DATA_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  logic [7:0] got_mem [0:1023];
  int got_n = 0;
  int got_rd = 0;
  int stb_cnt [NCH];
  int stb_total = 0;
  int tx_low_cnt = 0;
  logic [NCH-1:0] last_stb = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge CLK);
      if (!RST && TX === 1'b0) begin
        repeat (BIT / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge CLK);
          b[i] = TX;
        end
        repeat (BIT) @(negedge CLK);
        if (got_n < 1024) got_mem[got_n] = b;
        got_n++;
      end
    end
  end

  initial for (int c = 0; c < NCH; c++) stb_cnt[c] = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (TX === 1'b0) tx_low_cnt++;
      if (DATA_IN_STB != '0) begin
        last_stb = DATA_IN_STB;
        stb_total++;
        for (int c = 0; c < NCH; c++) if (DATA_IN_STB[c]) stb_cnt[c]++;
      end
    end
  end

  function automatic logic [7:0] hx(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'(8'h30 + n);
    return 8'((lower ? 8'h61 : 8'h41) + n - 4'd10);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (BIT) @(negedge CLK);
    end
  endtask

  task automatic send_hex(input logic [DW-1:0] v, input bit lower);
    for (int i = NIB - 1; i >= 0; i--) send_byte(hx(4'(v >> (4 * i)), lower));
  endtask

  task automatic push_d(input logic [3:0] ch, input logic [DW-1:0] v);
    exp_q.push_back("D");
    exp_q.push_back(hx(ch, 1'b0));
    for (int i = NIB - 1; i >= 0; i--) exp_q.push_back(hx(4'(v >> (4 * i)), 1'b0));
    exp_q.push_back(8'h0A);
  endtask

  // pair=1: two frames whose arrival order depends on the scan pointer; sort by channel digit
  task automatic drain(input string tag, input bit pair);
    int n, base, idx;
    bit swap;
    n = exp_q.size();
    for (int i = 0; i < n * 400 + 400 && (got_n - got_rd) < n; i++) @(negedge CLK);
    chk({tag, "_len"}, 64'(got_n - got_rd), 64'(n));
    base = got_rd;
    swap = pair && (got_n - got_rd >= n) && (got_mem[base + 1] != exp_q[1]);
    for (int i = 0; i < n; i++) begin
      idx = swap ? base + ((i + FL) % (2 * FL)) : base + i;
      if (idx < got_n) chk(tag, got_mem[idx], exp_q[i]);
    end
    exp_q.delete();
    got_rd = (got_n > base + n) ? base + n : got_n;
  endtask

  logic [DW-1:0] w_a, w_b, w_c, w_d;
  int s0 [NCH];
  int t0, l0;

  initial begin
    w_a = DW'(32'h1234_56A5);
    w_b = DW'(32'h0000_BC7F);
    w_c = DW'(32'h0000_9E6D);
    w_d = DW'(32'h0000_5A3C);
    RST = 1'b1;
    RX = 1'b1;
    DATA_OUT = '0;
    repeat (3) @(negedge CLK);
    chk("rst_data_in", DATA_IN, '0);
    chk("rst_stb", DATA_IN_STB, '0);
    chk("rst_tx", TX, 1'b1);
    RST = 1'b0;

    l0 = tx_low_cnt;
    repeat (2000) @(negedge CLK);
    chk("idle_tx_low", 64'(tx_low_cnt - l0), 0);
    chk("idle_bytes", 64'(got_n), 0);
    chk("idle_stb", 64'(stb_total), 0);
    chk("idle_data_in", DATA_IN, '0);

    send_byte("S"); send_byte("2"); send_hex(w_a, 1'b0);
    repeat (5) @(negedge CLK);
    chk("wr_ch2", DATA_IN[2*DW +: DW], w_a);
    chk("wr_others", {DATA_IN[3*DW +: DW], DATA_IN[0 +: 2*DW]}, '0);
    chk("wr_stb_cnt", 64'(stb_cnt[2]), 1);
    chk("wr_stb_vec", last_stb, 4'b0100);
    chk("wr_stb_total", 64'(stb_total), 1);

    for (int c = 0; c < NCH; c++) s0[c] = stb_cnt[c];
    send_byte("S"); send_byte("1"); send_byte("G");
    for (int i = 0; i < NIB - 1; i++) send_byte("7");
    send_byte("S"); send_byte("0"); send_hex(w_b, 1'b1);
    repeat (5) @(negedge CLK);
    chk("abort_ch1", DATA_IN[1*DW +: DW], '0);
    chk("abort_stb1", 64'(stb_cnt[1] - s0[1]), 0);
    chk("lower_ch0", DATA_IN[0 +: DW], w_b);
    chk("lower_stb0", 64'(stb_cnt[0] - s0[0]), 1);

    t0 = stb_total;
    send_byte("S"); send_byte("9"); send_hex(w_a, 1'b0);
    repeat (5) @(negedge CLK);
    chk("oor_stb", 64'(stb_total - t0), 0);
    chk("oor_data", DATA_IN, {DW'(0), w_a, DW'(0), w_b});

    s0[3] = stb_cnt[3];
    send_byte("S"); send_byte("3"); send_byte("1");
    send_byte("S"); send_byte("3"); send_hex(w_c, 1'b0);
    repeat (5) @(negedge CLK);
    chk("restart_ch3", DATA_IN[3*DW +: DW], w_c);
    chk("restart_stb3", 64'(stb_cnt[3] - s0[3]), 1);

`ifndef COM_QUERY_EN
    send_byte("R"); send_byte("1");
    repeat (600) @(negedge CLK);
    chk("r_ignored", 64'(got_n - got_rd), 0);
`endif

    DATA_OUT[1*DW +: DW] = w_d;
    push_d(4'd1, w_d);
    drain("chg_ch1", 1'b0);
    repeat (1500) @(negedge CLK);
    chk("no_repeat", 64'(got_n - got_rd), 0);

    DATA_OUT[0 +: DW] = DW'(1);
    DATA_OUT[3*DW +: DW] = '1;
    push_d(4'd0, DW'(1));
    push_d(4'd3, '1);
    drain("pair", 1'b1);

`ifdef COM_QUERY_EN
    DATA_OUT[2*DW +: DW] = DW'(32'hBEEF);
    push_d(4'd2, DW'(32'hBEEF));
    drain("chg_ch2", 1'b0);
    push_d(4'd2, DW'(32'hBEEF));
    send_byte("R"); send_byte("2");
    drain("query_ok", 1'b0);
    exp_q.push_back("E"); exp_q.push_back("9"); exp_q.push_back(8'h0A);
    send_byte("R"); send_byte("9");
    drain("query_err", 1'b0);
`endif

    repeat (BIT * 2) @(negedge CLK);
    s0[1] = stb_cnt[1];
    send_byte("S"); send_byte("1"); send_byte("4");
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (DATA_OUT[c*DW +: DW] != '0) push_d(4'(c), DATA_OUT[c*DW +: DW]);
    for (int i = 0; i < NIB - 1; i++) send_byte("4");
    drain("post_rst", 1'b0);
    chk("post_rst_data_in", DATA_IN, '0);
    chk("post_rst_stb1", 64'(stb_cnt[1] - s0[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
